rf_bus_arbiter: RTL and testbench

//  Shares the single RF transceiver register interface between NUM_REQ requesters, e.g. the program sequencer and the RX/interrupt service path.

---
 rtl/rf_pkg.sv | 39 +++
 rtl/rf_rr_pick.sv | 35 +++
 rtl/rf_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_rf_bus_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and constants for the RF register-interface arbiter slice.
//   rf_inst_t    : RF register instruction encoding (short/long, read/write)
//   arb_state_t  : arbiter transaction FSM states
//   RF_ADDR_W    : RF register address width
//   RF_DATA_W    : RF register data width
//   rf_mask_addr : clears the upper address bits for short instructions
package rf_pkg;

    localparam int unsigned RF_ADDR_W = 10;
    localparam int unsigned RF_DATA_W = 8;

    typedef enum logic [1:0] {
        SHORT_RD = 2'b00,
        SHORT_WR = 2'b01,
        LONG_RD  = 2'b10,
        LONG_WR  = 2'b11
    } rf_inst_t;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StStrobe,
        StSettle,
        StWaitRdy,
        StDone
    } arb_state_t;

    // Short instructions only reach the low 64 registers; addr[9:6] must be zero.
    function automatic logic [RF_ADDR_W-1:0] rf_mask_addr(input logic [1:0] inst,
                                                          input logic [RF_ADDR_W-1:0] addr);
        logic [RF_ADDR_W-1:0] masked;
        masked = addr;
        if (inst == SHORT_RD || inst == SHORT_WR) begin
            masked[RF_ADDR_W-1:6] = '0;
        end
        return masked;
    endfunction

endpackage

// File: rtl/rf_rr_pick.sv
// Combinational round-robin picker.
//   i_req    : request vector
//   i_ptr    : index with highest priority this round
//   o_onehot : one-hot winner (zero when no request)
//   o_idx    : winner index
//   o_valid  : at least one request present
module rf_rr_pick #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_valid
);

    // Scan from the pointer upward, wrapping; the first set bit wins.
    always_comb begin
        int w_j;
        w_j      = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_j = (int'(i_ptr) + i) % int'(NUM_REQ);
            if (!o_valid && i_req[w_j]) begin
                o_valid       = 1'b1;
                o_onehot[w_j] = 1'b1;
                o_idx         = IDX_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/rf_bus_arbiter.sv
// Round-robin arbiter sharing the RF transceiver register interface.
// Runs one register transaction at a time: setup, one-cycle strobe, settle,
// ready wait (with timeout), then a one-cycle ack with read data.
//   clk, rst               : clock, asynchronous active-high reset
//   i_req                  : per-requester level request
//   i_req_inst/addr/wdata  : packed per-requester transaction fields
//   o_gnt                  : one-hot grant, latch through ack inclusive
//   o_ack                  : one-cycle completion pulse to the winner
//   o_rdata, o_err         : read data / timeout flag, valid with ack
//   o_busy                 : any state other than idle
//   o_rf_addr/wdata/inst   : RF interface transaction fields
//   o_rf_cs                : one-cycle RF transaction strobe
//   i_rf_ready, i_rf_rdata : RF interface done flag and read data
module rf_bus_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned SETUP_CYC   = 2,
    parameter int unsigned SETTLE_CYC  = 3,
    parameter int unsigned TIMEOUT_CYC = 4095
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             i_req,
    input  logic [2*NUM_REQ-1:0]           i_req_inst,
    input  logic [RF_ADDR_W*NUM_REQ-1:0]   i_req_addr,
    input  logic [RF_DATA_W*NUM_REQ-1:0]   i_req_wdata,
    output logic [NUM_REQ-1:0]             o_gnt,
    output logic [NUM_REQ-1:0]             o_ack,
    output logic [RF_DATA_W-1:0]           o_rdata,
    output logic                           o_err,
    output logic                           o_busy,
    output logic [RF_ADDR_W-1:0]           o_rf_addr,
    output logic [RF_DATA_W-1:0]           o_rf_wdata,
    output logic [1:0]                     o_rf_inst,
    output logic                           o_rf_cs,
    input  logic                           i_rf_ready,
    input  logic [RF_DATA_W-1:0]           i_rf_rdata
);

    localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_MAX = (TIMEOUT_CYC > SETUP_CYC) ?
                                      ((TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC) :
                                      ((SETUP_CYC > SETTLE_CYC) ? SETUP_CYC : SETTLE_CYC);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    arb_state_t             r_state, w_state_d;
    logic [CNT_W-1:0]       r_cnt, w_cnt_d;
    logic [IDX_W-1:0]       r_ptr, w_ptr_d;
    logic [IDX_W-1:0]       r_win, w_win_d;
    logic [NUM_REQ-1:0]     r_gnt, w_gnt_d;
    logic [NUM_REQ-1:0]     r_ack, w_ack_d;
    logic [RF_DATA_W-1:0]   r_rdata, w_rdata_d;
    logic                   r_err, w_err_d;
    logic                   r_busy, w_busy_d;
    logic [RF_ADDR_W-1:0]   r_rf_addr, w_rf_addr_d;
    logic [RF_DATA_W-1:0]   r_rf_wdata, w_rf_wdata_d;
    logic [1:0]             r_rf_inst, w_rf_inst_d;
    logic                   r_rf_cs, w_rf_cs_d;

    logic [NUM_REQ-1:0]     w_pick_onehot;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;

    rf_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req    (i_req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // All outputs are registers; each is loaded on the transition into the
    // state in which it must be visible, so outputs line up with the state.
    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_ptr_d      = r_ptr;
        w_win_d      = r_win;
        w_gnt_d      = r_gnt;
        w_ack_d      = '0;
        w_rdata_d    = '0;
        w_err_d      = 1'b0;
        w_busy_d     = r_busy;
        w_rf_addr_d  = r_rf_addr;
        w_rf_wdata_d = r_rf_wdata;
        w_rf_inst_d  = r_rf_inst;
        w_rf_cs_d    = 1'b0;

        unique case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_state_d    = StIssue;
                    w_cnt_d      = '0;
                    w_win_d      = w_pick_idx;
                    w_gnt_d      = w_pick_onehot;
                    w_busy_d     = 1'b1;
                    w_rf_inst_d  = i_req_inst[w_pick_idx*2 +: 2];
                    w_rf_addr_d  = rf_mask_addr(i_req_inst[w_pick_idx*2 +: 2],
                                                i_req_addr[w_pick_idx*RF_ADDR_W +: RF_ADDR_W]);
                    w_rf_wdata_d = i_req_wdata[w_pick_idx*RF_DATA_W +: RF_DATA_W];
                end
            end
            StIssue: begin
                if (r_cnt == CNT_W'(SETUP_CYC - 1)) begin
                    w_state_d = StStrobe;
                    w_cnt_d   = '0;
                    w_rf_cs_d = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StStrobe: begin
                w_state_d = StSettle;
                w_cnt_d   = '0;
            end
            StSettle: begin
                if (r_cnt == CNT_W'(SETTLE_CYC - 1)) begin
                    w_state_d = StWaitRdy;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StWaitRdy: begin
                // A ready seen on the last allowed cycle still wins over timeout.
                if (i_rf_ready) begin
                    w_state_d = StDone;
                    w_ack_d   = r_gnt;
                    w_rdata_d = i_rf_rdata;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_state_d = StDone;
                    w_ack_d   = r_gnt;
                    w_err_d   = 1'b1;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StDone: begin
                w_state_d    = StIdle;
                w_cnt_d      = '0;
                w_gnt_d      = '0;
                w_busy_d     = 1'b0;
                w_rf_addr_d  = '0;
                w_rf_wdata_d = '0;
                w_rf_inst_d  = '0;
                w_ptr_d      = (r_win == IDX_W'(NUM_REQ - 1)) ? '0 : r_win + IDX_W'(1);
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_ptr      <= '0;
            r_win      <= '0;
            r_gnt      <= '0;
            r_ack      <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_rf_addr  <= '0;
            r_rf_wdata <= '0;
            r_rf_inst  <= '0;
            r_rf_cs    <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_cnt      <= w_cnt_d;
            r_ptr      <= w_ptr_d;
            r_win      <= w_win_d;
            r_gnt      <= w_gnt_d;
            r_ack      <= w_ack_d;
            r_rdata    <= w_rdata_d;
            r_err      <= w_err_d;
            r_busy     <= w_busy_d;
            r_rf_addr  <= w_rf_addr_d;
            r_rf_wdata <= w_rf_wdata_d;
            r_rf_inst  <= w_rf_inst_d;
            r_rf_cs    <= w_rf_cs_d;
        end
    end

    assign o_gnt      = r_gnt;
    assign o_ack      = r_ack;
    assign o_rdata    = r_rdata;
    assign o_err      = r_err;
    assign o_busy     = r_busy;
    assign o_rf_addr  = r_rf_addr;
    assign o_rf_wdata = r_rf_wdata;
    assign o_rf_inst  = r_rf_inst;
    assign o_rf_cs    = r_rf_cs;

endmodule

// File: tb/tb_rf_bus_arbiter.sv
// Self-checking bench for rf_bus_arbiter: a transaction-level model predicts
// every output each cycle, plus literal expectations for the directed cases.
module tb_rf_bus_arbiter;
    import rf_pkg::*;

    localparam int N      = 2;
    localparam int SETUP  = 2;
    localparam int SETTLE = 3;
    localparam int TMO    = 4095;
    localparam int T_CS   = 1 + SETUP;               // sample cycle -> strobe cycle
    localparam int T_WAIT = 1 + SETUP + 1 + SETTLE;  // first cycle rf_ready counts

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [N-1:0]        req = '0;
    logic [2*N-1:0]      req_inst = '0;
    logic [10*N-1:0]     req_addr = '0;
    logic [8*N-1:0]      req_wdata = '0;
    logic [N-1:0]        gnt, ack;
    logic [7:0]          rdata;
    logic                err, busy;
    logic [9:0]          rf_addr;
    logic [7:0]          rf_wdata;
    logic [1:0]          rf_inst;
    logic                rf_cs;
    logic                rf_ready = 1'b1;
    logic [7:0]          rf_rdata = '0;

    rf_bus_arbiter #(
        .NUM_REQ     (N),
        .SETUP_CYC   (SETUP),
        .SETTLE_CYC  (SETTLE),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (req),
        .i_req_inst  (req_inst),
        .i_req_addr  (req_addr),
        .i_req_wdata (req_wdata),
        .o_gnt       (gnt),
        .o_ack       (ack),
        .o_rdata     (rdata),
        .o_err       (err),
        .o_busy      (busy),
        .o_rf_addr   (rf_addr),
        .o_rf_wdata  (rf_wdata),
        .o_rf_inst   (rf_inst),
        .o_rf_cs     (rf_cs),
        .i_rf_ready  (rf_ready),
        .i_rf_rdata  (rf_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // m_k: cycles elapsed since the sample cycle (0 = idle); m_done: ack cycle.
    int          m_k, m_win, m_ptr, m_waited;
    bit          m_done, m_err;
    logic [1:0]  m_inst;
    logic [9:0]  m_addr;
    logic [7:0]  m_wdata, m_rdata;
    logic [N-1:0] e_gnt, e_ack;
    logic [7:0]  e_rdata, e_rf_wdata;
    logic [9:0]  e_rf_addr;
    logic [1:0]  e_rf_inst;
    logic        e_err, e_busy, e_rf_cs;

    task automatic model_outputs();
        e_busy     = (m_k != 0);
        e_gnt      = e_busy ? N'(1 << m_win) : '0;
        e_ack      = m_done ? N'(1 << m_win) : '0;
        e_rdata    = m_done ? m_rdata : 8'h00;
        e_err      = m_done ? m_err : 1'b0;
        e_rf_addr  = e_busy ? m_addr : 10'h000;
        e_rf_wdata = e_busy ? m_wdata : 8'h00;
        e_rf_inst  = e_busy ? m_inst : 2'b00;
        e_rf_cs    = (m_k == T_CS);
    endtask

    task automatic model_reset();
        m_k = 0; m_win = 0; m_ptr = 0; m_waited = 0; m_done = 0; m_err = 0;
        m_inst = '0; m_addr = '0; m_wdata = '0; m_rdata = '0;
        model_outputs();
    endtask

    task automatic model_step();
        bit found;
        int j;
        found = 0;
        if (m_k == 0) begin
            for (int off = 0; off < N; off++) begin
                j = (m_ptr + off) % N;
                if (!found && req[j]) begin
                    found    = 1;
                    m_win    = j;
                    m_k      = 1;
                    m_waited = 0;
                    m_inst   = req_inst[2*j +: 2];
                    m_addr   = req_addr[10*j +: 10];
                    m_wdata  = req_wdata[8*j +: 8];
                    if (!m_inst[1]) m_addr = m_addr & 10'h03F;
                end
            end
        end else if (m_done) begin
            m_done = 0;
            m_k    = 0;
            m_ptr  = (m_win + 1) % N;
        end else begin
            if (m_k >= T_WAIT) begin
                m_waited++;
                if (rf_ready) begin
                    m_done = 1; m_rdata = rf_rdata; m_err = 0;
                end else if (m_waited == TMO) begin
                    m_done = 1; m_rdata = 8'h00; m_err = 1;
                end
            end
            if (!m_done) m_k++;
        end
        model_outputs();
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    // ---------------- compare / monitor ----------------
    typedef struct {
        int         idx;
        int         cyc;
        logic [7:0] rdata;
        logic       err;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [N-1:0] gnt;
    } ack_rec_t;

    ack_rec_t ack_q[$];
    int       cs_q[$];

    initial forever begin
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("rdata", 32'(rdata), 32'(e_rdata));
        chk("err", 32'(err), 32'(e_err));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("rf_addr", 32'(rf_addr), 32'(e_rf_addr));
        chk("rf_wdata", 32'(rf_wdata), 32'(e_rf_wdata));
        chk("rf_inst", 32'(rf_inst), 32'(e_rf_inst));
        chk("rf_cs", 32'(rf_cs), 32'(e_rf_cs));
        if (rf_cs) cs_q.push_back(cyc);
        if (|ack) begin
            ack_rec_t r;
            r.idx = -1;
            for (int i = 0; i < N; i++) if (ack[i]) r.idx = i;
            r.cyc = cyc; r.rdata = rdata; r.err = err;
            r.addr = rf_addr; r.wdata = rf_wdata; r.gnt = gnt;
            ack_q.push_back(r);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int j, input rf_inst_t inst, input logic [9:0] addr,
                           input logic [7:0] wd);
        req_inst[2*j +: 2]   = inst;
        req_addr[10*j +: 10] = addr;
        req_wdata[8*j +: 8]  = wd;
        req[j]               = 1'b1;
    endtask

    task automatic wait_acks(input int n, input int budget);
        int b;
        b = 0;
        while (ack_q.size() < n && b < budget) begin
            tick();
            b++;
        end
        n_checks++;
        if (ack_q.size() < n) begin
            n_err++;
            $display("FAIL wait_ack: got %0d acks required %0d within %0d cycles",
                     ack_q.size(), n, budget);
        end
    endtask

    // Literal check of the k-th logged ack.
    task automatic chk_ack(input string name, input int k, input int idx, input int dcyc,
                           input int t0, input logic [7:0] rd, input logic e,
                           input logic [9:0] addr);
        if (ack_q.size() > k) begin
            chk({name, "_idx"}, 32'(ack_q[k].idx), 32'(idx));
            chk({name, "_lat"}, 32'(ack_q[k].cyc - t0), 32'(dcyc));
            chk({name, "_rdata"}, 32'(ack_q[k].rdata), 32'(rd));
            chk({name, "_err"}, 32'(ack_q[k].err), 32'(e));
            chk({name, "_addr"}, 32'(ack_q[k].addr), 32'(addr));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int r;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_cs", 32'(rf_cs), 32'h0);
        chk("reset_addr", 32'(rf_addr), 32'h0);
        rst = 1'b0;
        tick(); tick();

        // Both requesters held, pointer 0: grants alternate 0,1,0,1.
        ack_q.delete();
        set_req(0, LONG_WR, 10'h155, 8'h11);
        set_req(1, SHORT_WR, 10'h022, 8'h22);
        rf_ready = 1'b1;
        wait_acks(4, 60);
        req = '0;
        for (int k = 0; k < 4; k++) begin
            if (ack_q.size() > k) begin
                chk("rr_order", 32'(ack_q[k].idx), 32'(k % 2));
                chk("rr_gnt", 32'(ack_q[k].gnt), (k % 2 == 0) ? 32'h1 : 32'h2);
            end
        end
        if (ack_q.size() > 1) chk("rr_spacing", 32'(ack_q[1].cyc - ack_q[0].cyc), 32'd9);
        tick(); tick(); tick();

        // Short write from requester 0: strobe 3 cycles, ack 8 cycles after sample.
        ack_q.delete(); cs_q.delete();
        set_req(0, SHORT_WR, 10'h012, 8'hA5);
        t = cyc;
        tick();
        req = '0; req_addr = '1; req_wdata = '1;
        wait_acks(1, 20);
        chk_ack("t1", 0, 0, 8, t, 8'h00, 1'b0, 10'h012);
        if (ack_q.size() > 0) chk("t1_wdata", 32'(ack_q[0].wdata), 32'hA5);
        chk("t1_cs_count", 32'(cs_q.size()), 32'd1);
        if (cs_q.size() > 0) chk("t1_cs_lat", 32'(cs_q[0] - t), 32'd3);
        tick(); tick();

        // Long read, rf_ready low for 10 cycles after the strobe.
        ack_q.delete(); cs_q.delete();
        rf_ready = 1'b0; rf_rdata = 8'h77;
        set_req(1, LONG_RD, 10'h301, 8'h00);
        t = cyc;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (i == 1) req = '0;
            if (i == 14) begin
                rf_ready = 1'b1;
                rf_rdata = 8'h3C;
            end
        end
        wait_acks(1, 10);
        chk_ack("t3", 0, 1, 15, t, 8'h3C, 1'b0, 10'h301);
        if (cs_q.size() > 0) chk("t3_cs_lat", 32'(cs_q[0] - t), 32'd3);
        tick(); tick();

        // Short read with high address bits set: they are dropped.
        ack_q.delete();
        rf_rdata = 8'h99;
        set_req(0, SHORT_RD, 10'h3F5, 8'h00);
        t = cyc;
        tick();
        req = '0;
        tick();
        chk("t4_issue_addr", 32'(rf_addr), 32'h035);
        wait_acks(1, 20);
        chk_ack("t4", 0, 0, 8, t, 8'h99, 1'b0, 10'h035);
        tick(); tick();

        // rf_ready stuck low: timeout ack with err, then a normal transaction.
        ack_q.delete();
        rf_ready = 1'b0; rf_rdata = 8'hEE;
        set_req(1, SHORT_WR, 10'h0AA, 8'h5A);
        t = cyc;
        tick();
        req = '0;
        wait_acks(1, TMO + 40);
        chk_ack("t5_tmo", 0, 1, T_WAIT + TMO, t, 8'h00, 1'b1, 10'h02A);
        rf_ready = 1'b1;
        tick();
        ack_q.delete();
        rf_rdata = 8'h5A;
        set_req(0, SHORT_RD, 10'h004, 8'h00);
        t = cyc;
        tick();
        req = '0;
        wait_acks(1, 20);
        chk_ack("t5_next", 0, 0, 8, t, 8'h5A, 1'b0, 10'h004);
        tick(); tick();

        // Reset during the ready wait, both requesters pending afterwards.
        ack_q.delete();
        rf_ready = 1'b0;
        set_req(0, LONG_RD, 10'h200, 8'h00);
        t = cyc;
        tick();
        req = '0;
        repeat (8) tick();
        set_req(1, LONG_WR, 10'h111, 8'h33);
        set_req(0, LONG_RD, 10'h200, 8'h00);
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'h0);
        chk("t6_rst_ack", 32'(ack), 32'h0);
        chk("t6_rst_addr", 32'(rf_addr), 32'h0);
        chk("t6_rst_inst", 32'(rf_inst), 32'h0);
        tick(); tick();
        rf_ready = 1'b1; rf_rdata = 8'h42;
        rst = 1'b0;
        r = cyc;
        tick();
        req = '0;
        wait_acks(1, 20);
        chk_ack("t6_after", 0, 0, 8, r, 8'h42, 1'b0, 10'h200);
        tick(); tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
